// File: rtl/ar_rxd.sv
// ar_rxd: bipolar return-to-zero serial receiver for the RXD1/RXD0 line pair.
// Recovers 32-bit words (8-bit label, 23-bit data, odd parity) at one of
// four selectable rates and presents each completed word with a strobe.
module ar_rxd #(
   parameter int unsigned Fclk    = 50_000_000,
   parameter int unsigned V1Mb    = 1_000_000,
   parameter int unsigned V100kb  = 100_000,
   parameter int unsigned V50kb   = 50_000,
   parameter int unsigned V12_5kb = 12_500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  Nvel,
   input  logic        RXD1,
   input  logic        RXD0,
   output logic [7:0]  ADR,
   output logic [22:0] DAT,
   output logic        ce_wr,
   output logic        ok_par,
   output logic        err_both,
   output logic        err_tmo,
   output logic        en_rx,
   output logic [5:0]  cb_bit
);

   // Half-bit periods in clocks for each rate select value
   localparam logic [10:0] C_NT3 = 11'(Fclk / (2 * V1Mb));
   localparam logic [10:0] C_NT2 = 11'(Fclk / (2 * V100kb));
   localparam logic [10:0] C_NT1 = 11'(Fclk / (2 * V50kb));
   localparam logic [10:0] C_NT0 = 11'(Fclk / (2 * V12_5kb));

   // Synchronized line codes, {RXD1, RXD0}
   localparam logic [1:0] L_NUL = 2'b00;
   localparam logic [1:0] L_P0  = 2'b01;
   localparam logic [1:0] L_P1  = 2'b10;
   localparam logic [1:0] L_BAD = 2'b11;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_RX
   } state_t;

   state_t      r_state;
   logic [1:0]  r_sync1;
   logic [1:0]  r_sync2;
   logic [1:0]  r_line_q;
   logic [10:0] r_fcnt;
   logic [12:0] r_gap;
   logic        r_armed;
   logic [1:0]  r_nvel;
   logic [31:0] r_word;
   logic [5:0]  r_cb;
   logic        r_done;

   logic [10:0] w_nt;
   logic [10:0] w_nf;
   logic [12:0] w_tgap;
   logic        w_nchg;
   logic        w_same;
   logic        w_fhit;
   logic        w_acc;
   logic        w_bad;
   logic        w_gfull;
   logic        w_bit;
   logic [7:0]  w_adr;

   // Timing constants for the currently selected rate
   always_comb begin
      w_nt = C_NT0;
      case (r_nvel)
         2'd3:    w_nt = C_NT3;
         2'd2:    w_nt = C_NT2;
         2'd1:    w_nt = C_NT1;
         default: w_nt = C_NT0;
      endcase
      w_nf   = w_nt >> 1;
      w_tgap = {w_nt, 2'b00};
   end

   // The first line bit is the label MSB, so the label is bit-reversed
   always_comb begin
      w_adr = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w_adr[7-i] = r_word[i];
      end
   end

   assign w_nchg  = (Nvel != r_nvel);
   assign w_same  = (r_sync2 == r_line_q);
   // Filter counter is about to reach Nf with the line state unchanged
   assign w_fhit  = w_same && (r_fcnt == (w_nf - 11'd1));
   assign w_acc   = w_fhit && r_armed && ((r_sync2 == L_P0) || (r_sync2 == L_P1));
   assign w_bad   = w_fhit && (r_sync2 == L_BAD);
   assign w_gfull = (r_sync2 == L_NUL) && (r_gap >= (w_tgap - 13'd1));
   assign w_bit   = (r_sync2 == L_P1);

   assign en_rx  = (r_state == ST_RX);
   assign cb_bit = r_cb;

   // Line synchronizer, pulse-width filter, arming and inter-bit gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_line_q <= '0;
         r_fcnt   <= '0;
         r_gap    <= '0;
         r_armed  <= 1'b0;
         r_nvel   <= '0;
      end else begin
         r_sync1  <= {RXD1, RXD0};
         r_sync2  <= r_sync1;
         r_line_q <= r_sync2;
         r_nvel   <= Nvel;
         if (w_nchg) begin
            r_fcnt  <= '0;
            r_gap   <= '0;
            r_armed <= 1'b0;
         end else begin
            if (!w_same) begin
               r_fcnt <= 11'd1;
            end else if (r_fcnt < w_nf) begin
               r_fcnt <= r_fcnt + 11'd1;
            end

            if (r_sync2 != L_NUL) begin
               r_gap <= '0;
            end else if (r_gap < w_tgap) begin
               r_gap <= r_gap + 13'd1;
            end

            if (w_fhit && (r_sync2 == L_NUL)) begin
               r_armed <= 1'b1;
            end else if (w_acc) begin
               r_armed <= 1'b0;
            end
         end
      end
   end

   // Word framing state machine, word assembly and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_SYNC;
         r_word   <= '0;
         r_cb     <= '0;
         r_done   <= 1'b0;
         ADR      <= '0;
         DAT      <= '0;
         ok_par   <= 1'b0;
         ce_wr    <= 1'b0;
         err_both <= 1'b0;
         err_tmo  <= 1'b0;
      end else begin
         ce_wr    <= 1'b0;
         err_both <= 1'b0;
         err_tmo  <= 1'b0;

         // Completion is presented one cycle after bit 31 lands in r_word
         if (r_done) begin
            ADR    <= w_adr;
            DAT    <= r_word[30:8];
            ok_par <= ^r_word;
            ce_wr  <= 1'b1;
            r_done <= 1'b0;
         end

         if (w_nchg) begin
            r_state <= ST_SYNC;
            r_cb    <= '0;
         end else if (w_bad) begin
            err_both <= 1'b1;
            r_state  <= ST_SYNC;
            r_cb     <= '0;
         end else begin
            case (r_state)
               ST_SYNC: begin
                  if (w_gfull) begin
                     r_state <= ST_IDLE;
                     r_cb    <= '0;
                  end
               end
               ST_IDLE: begin
                  if (w_acc) begin
                     r_word[0] <= w_bit;
                     r_cb      <= 6'd1;
                     r_state   <= ST_RX;
                  end
               end
               ST_RX: begin
                  if (w_acc) begin
                     r_word[r_cb[4:0]] <= w_bit;
                     r_cb              <= r_cb + 6'd1;
                     if (r_cb == 6'd31) begin
                        r_done  <= 1'b1;
                        r_state <= ST_SYNC;
                     end
                  end else if (w_gfull) begin
                     err_tmo <= 1'b1;
                     r_cb    <= '0;
                     r_state <= ST_IDLE;
                  end
               end
               default: begin
                  r_state <= ST_SYNC;
                  r_cb    <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ar_rxd.sv
// tb_ar_rxd: scoreboard bench for ar_rxd. Words are generated from label,
// data and parity choices; expected outputs and strobe cycles come from the
// bench's own model of the line timing.
module tb_ar_rxd;

   // The slowest rate is raised so the whole run stays short
   localparam int unsigned FCLK = 50_000_000;
   localparam int unsigned R3   = 1_000_000;
   localparam int unsigned R2   = 100_000;
   localparam int unsigned R1   = 50_000;
   localparam int unsigned R0   = 250_000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  Nvel;
   logic        RXD1;
   logic        RXD0;
   logic [7:0]  ADR;
   logic [22:0] DAT;
   logic        ce_wr;
   logic        ok_par;
   logic        err_both;
   logic        err_tmo;
   logic        en_rx;
   logic [5:0]  cb_bit;

   typedef struct {
      logic [7:0]  adr;
      logic [22:0] dat;
      logic        par;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc       = 0;
   int unsigned n_cmp     = 0;
   int unsigned n_bad     = 0;
   int unsigned tmo_cnt   = 0;
   int unsigned tmo_cyc   = 0;
   int unsigned both_cnt  = 0;
   int unsigned both_cyc  = 0;
   int unsigned last_fall = 0;
   logic [7:0]  hold_adr  = '0;
   logic [22:0] hold_dat  = '0;
   logic        hold_par  = 1'b0;

   always #5 clk = ~clk;

   ar_rxd #(
      .Fclk    (FCLK),
      .V1Mb    (R3),
      .V100kb  (R2),
      .V50kb   (R1),
      .V12_5kb (R0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Nvel     (Nvel),
      .RXD1     (RXD1),
      .RXD0     (RXD0),
      .ADR      (ADR),
      .DAT      (DAT),
      .ce_wr    (ce_wr),
      .ok_par   (ok_par),
      .err_both (err_both),
      .err_tmo  (err_tmo),
      .en_rx    (en_rx),
      .cb_bit   (cb_bit)
   );

   function automatic int unsigned nt_of(input logic [1:0] v);
      case (v)
         2'd3:    return FCLK / (2 * R3);
         2'd2:    return FCLK / (2 * R2);
         2'd1:    return FCLK / (2 * R1);
         default: return FCLK / (2 * R0);
      endcase
   endfunction

   // Line bit i is word bit i; parity bit chosen for an odd total unless inverted
   function automatic logic [31:0] mk_word(input logic [7:0] adr, input logic [22:0] dat,
                                           input logic inv_par);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) w[i] = adr[7-i];
      w[30:8] = dat;
      w[31]   = ~(^adr ^ ^dat) ^ inv_par;
      return w;
   endfunction

   // Scoreboard side: sample DUT outputs on the falling edge
   task automatic sample();
      exp_t e;
      if (ce_wr === 1'b1) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL ce_wr_unexpected: strobe at cycle %0d, expected none", cyc);
         end else begin
            e = q.pop_front();
            if (ADR !== e.adr || DAT !== e.dat || ok_par !== e.par || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL word_out: got ADR=%h DAT=%h ok_par=%b at cycle %0d, expected ADR=%h DAT=%h ok_par=%b at cycle %0d",
                        ADR, DAT, ok_par, cyc, e.adr, e.dat, e.par, e.cyc);
            end
            hold_adr = e.adr;
            hold_dat = e.dat;
            hold_par = e.par;
         end
      end
      if (err_tmo === 1'b1) begin
         tmo_cnt++;
         tmo_cyc = cyc;
      end
      if (err_both === 1'b1) begin
         both_cnt++;
         both_cyc = cyc;
      end
      if (int'(ce_wr) + int'(err_tmo) + int'(err_both) > 1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL strobe_overlap: ce_wr=%b err_tmo=%b err_both=%b at cycle %0d, expected at most one",
                  ce_wr, err_tmo, err_both, cyc);
      end
   endtask

   // Advance n rising edges, sampling each cycle; returns 1 time unit after the edge
   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         sample();
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   // Send line bits lo..hi; bit 31 pushes the expected word and its ce_wr cycle
   task automatic send_bits(input logic [31:0] w, input int lo, input int hi,
                            input int unsigned nt, input bit push);
      exp_t e;
      for (int i = lo; i <= hi; i++) begin
         if (push && i == 31) begin
            for (int j = 0; j < 8; j++) e.adr[7-j] = w[j];
            e.dat = w[30:8];
            e.par = ^w;
            e.cyc = cyc + (nt >> 1) + 3;
            q.push_back(e);
         end
         {RXD1, RXD0} = w[i] ? 2'b10 : 2'b01;
         tick(nt);
         {RXD1, RXD0} = 2'b00;
         last_fall = cyc;
         tick(nt);
      end
   endtask

   task automatic test_reset();
      tick(3);
      n_cmp++;
      if ({ADR, DAT, ok_par, ce_wr, err_both, err_tmo, en_rx, cb_bit} !== 43'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got ADR=%h DAT=%h ok_par=%b ce_wr=%b err_both=%b err_tmo=%b en_rx=%b cb_bit=%0d, expected all 0",
                  ADR, DAT, ok_par, ce_wr, err_both, err_tmo, en_rx, cb_bit);
      end
      rst_n = 1'b1;
      tick(150);
      n_cmp++;
      if (en_rx !== 1'b0 || cb_bit !== 6'd0) begin
         n_bad++;
         $display("FAIL idle_after_reset: got en_rx=%b cb_bit=%0d, expected 0/0", en_rx, cb_bit);
      end
   endtask

   task automatic test_good_word();
      logic [31:0] w;
      w = mk_word(8'hA5, 23'h2AAAAA, 1'b0);
      send_bits(w, 0, 15, nt_of(2'd3), 1'b0);
      n_cmp++;
      if (en_rx !== 1'b1 || cb_bit !== 6'd16) begin
         n_bad++;
         $display("FAIL mid_word: got en_rx=%b cb_bit=%0d, expected 1/16", en_rx, cb_bit);
      end
      send_bits(w, 16, 31, nt_of(2'd3), 1'b1);
      n_cmp++;
      if (q.size() != 0 || cb_bit !== 6'd32 || en_rx !== 1'b0 || ok_par !== 1'b1) begin
         n_bad++;
         $display("FAIL good_word_end: got pending=%0d cb_bit=%0d en_rx=%b ok_par=%b, expected 0/32/0/1",
                  q.size(), cb_bit, en_rx, ok_par);
      end
      tick(8 * nt_of(2'd3));
   endtask

   task automatic test_bad_parity();
      send_bits(mk_word(8'hA5, 23'h2AAAAA, 1'b1), 0, 31, nt_of(2'd3), 1'b1);
      n_cmp++;
      if (q.size() != 0 || ok_par !== 1'b0 || ADR !== 8'hA5 || DAT !== 23'h2AAAAA) begin
         n_bad++;
         $display("FAIL bad_parity: got pending=%0d ok_par=%b ADR=%h DAT=%h, expected 0/0/a5/2aaaaa",
                  q.size(), ok_par, ADR, DAT);
      end
      tick(8 * nt_of(2'd3));
   endtask

   task automatic test_slow_pair();
      Nvel = 2'd0;
      tick(4 * nt_of(2'd0) + 100);
      send_bits(mk_word(8'h3C, 23'h000001, 1'b0), 0, 31, nt_of(2'd0), 1'b1);
      tick(8 * nt_of(2'd0));
      send_bits(mk_word(8'hFF, 23'h7FFFFF, 1'b0), 0, 31, nt_of(2'd0), 1'b1);
      n_cmp++;
      if (q.size() != 0 || cb_bit !== 6'd32) begin
         n_bad++;
         $display("FAIL slow_pair: got pending=%0d cb_bit=%0d, expected 0/32", q.size(), cb_bit);
      end
      tick(8 * nt_of(2'd0));
   endtask

   task automatic test_timeout();
      int unsigned t0;
      int unsigned nt;
      Nvel = 2'd2;
      nt   = nt_of(2'd2);
      tick(4 * nt + 200);
      t0 = tmo_cnt;
      send_bits(mk_word(8'h5A, 23'h123456, 1'b0), 0, 11, nt, 1'b0);
      n_cmp++;
      if (cb_bit !== 6'd12 || en_rx !== 1'b1) begin
         n_bad++;
         $display("FAIL partial_word: got cb_bit=%0d en_rx=%b, expected 12/1", cb_bit, en_rx);
      end
      tick(2000 - nt);
      n_cmp++;
      if (tmo_cnt - t0 != 1 || tmo_cyc != last_fall + 4 * nt + 2) begin
         n_bad++;
         $display("FAIL timeout_strobe: got count=%0d at cycle %0d, expected 1 at cycle %0d",
                  tmo_cnt - t0, tmo_cyc, last_fall + 4 * nt + 2);
      end
      n_cmp++;
      if (cb_bit !== 6'd0 || en_rx !== 1'b0 || ADR !== hold_adr || DAT !== hold_dat || ok_par !== hold_par) begin
         n_bad++;
         $display("FAIL timeout_discard: got cb_bit=%0d en_rx=%b ADR=%h DAT=%h, expected 0/0/%h/%h",
                  cb_bit, en_rx, ADR, DAT, hold_adr, hold_dat);
      end
      send_bits(mk_word(8'h81, 23'h0F0F0F, 1'b0), 0, 31, nt, 1'b1);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL word_after_timeout: got pending=%0d, expected 0", q.size());
      end
      tick(8 * nt);
   endtask

   task automatic test_both_glitch();
      int unsigned b0;
      int unsigned e0;
      int unsigned nt;
      logic [31:0] w;
      Nvel = 2'd3;
      nt   = nt_of(2'd3);
      tick(4 * nt + 50);
      w  = mk_word(8'h12, 23'h345678, 1'b0);
      b0 = both_cnt;
      send_bits(w, 0, 9, nt, 1'b0);
      {RXD1, RXD0} = 2'b11;
      e0 = cyc;
      tick(12);
      {RXD1, RXD0} = 2'b00;
      tick(nt);
      n_cmp++;
      if (both_cnt - b0 != 1 || both_cyc != e0 + (nt >> 1) + 2) begin
         n_bad++;
         $display("FAIL err_both_strobe: got count=%0d at cycle %0d, expected 1 at cycle %0d",
                  both_cnt - b0, both_cyc, e0 + (nt >> 1) + 2);
      end
      n_cmp++;
      if (cb_bit !== 6'd0 || en_rx !== 1'b0) begin
         n_bad++;
         $display("FAIL err_both_discard: got cb_bit=%0d en_rx=%b, expected 0/0", cb_bit, en_rx);
      end
      tick(50);
      send_bits(w, 0, 0, nt, 1'b0);
      n_cmp++;
      if (cb_bit !== 6'd0 || en_rx !== 1'b0) begin
         n_bad++;
         $display("FAIL sync_ignore: got cb_bit=%0d en_rx=%b, expected 0/0", cb_bit, en_rx);
      end
      tick(8 * nt);
      send_bits(w, 0, 31, nt, 1'b1);
      tick(8 * nt);
      RXD1 = 1'b1;
      tick(5);
      RXD1 = 1'b0;
      tick(50);
      n_cmp++;
      if (cb_bit !== 6'd0 || en_rx !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_rejected: got cb_bit=%0d en_rx=%b, expected 0/0", cb_bit, en_rx);
      end
      send_bits(mk_word(8'hC3, 23'h555555, 1'b0), 0, 31, nt, 1'b1);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL words_after_errors: got pending=%0d, expected 0", q.size());
      end
      tick(8 * nt);
   endtask

   task automatic test_reset_midword();
      int unsigned nt;
      logic [31:0] w;
      nt = nt_of(2'd3);
      w  = mk_word(8'h66, 23'h0ABCDE, 1'b0);
      send_bits(w, 0, 19, nt, 1'b0);
      RXD1 = 1'b1;
      tick(5);
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({ADR, DAT, ok_par, ce_wr, err_both, err_tmo, en_rx, cb_bit} !== 43'd0) begin
         n_bad++;
         $display("FAIL async_reset: got ADR=%h DAT=%h ok_par=%b en_rx=%b cb_bit=%0d, expected all 0",
                  ADR, DAT, ok_par, en_rx, cb_bit);
      end
      hold_adr = '0;
      hold_dat = '0;
      hold_par = 1'b0;
      tick(3);
      RXD1  = 1'b0;
      rst_n = 1'b1;
      send_bits(w, 0, 31, nt, 1'b0);
      n_cmp++;
      if (cb_bit !== 6'd0 || en_rx !== 1'b0 || ADR !== 8'h00) begin
         n_bad++;
         $display("FAIL word_after_release: got cb_bit=%0d en_rx=%b ADR=%h, expected 0/0/00", cb_bit, en_rx, ADR);
      end
      tick(8 * nt);
      send_bits(w, 0, 31, nt, 1'b1);
      n_cmp++;
      if (q.size() != 0 || ADR !== 8'h66 || DAT !== 23'h0ABCDE) begin
         n_bad++;
         $display("FAIL word_after_gap: got pending=%0d ADR=%h DAT=%h, expected 0/66/0abcde", q.size(), ADR, DAT);
      end
      tick(8 * nt);
   endtask

   initial begin
      rst_n = 1'b0;
      Nvel  = 2'd3;
      RXD1  = 1'b0;
      RXD0  = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_good_word();
      test_bad_parity();
      test_slow_pair();
      test_timeout();
      test_both_glitch();
      test_reset_midword();
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d words never output, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
